// File: rtl/timer_launcher_if.sv
// Request/response and timer-side signals of the timer launcher.
// slave is the launcher's view, master is the requester/timer view.
interface timer_launcher_if;
  logic       req_valid;
  logic [3:0] req_delay;
  logic       req_ready;
  logic       ser_out;
  logic       tmr_counting;
  logic       tmr_done;
  logic       ack;
  logic       rsp_valid;
  logic       rsp_err;
  logic [3:0] rsp_delay;

  modport slave (
    input  req_valid, req_delay, tmr_counting, tmr_done,
    output req_ready, ser_out, ack, rsp_valid, rsp_err, rsp_delay
  );

  modport master (
    output req_valid, req_delay, tmr_counting, tmr_done,
    input  req_ready, ser_out, ack, rsp_valid, rsp_err, rsp_delay
  );
endinterface

// File: rtl/timer_launcher.sv
// Serialises 1101+delay onto the timer line after GAP idle cycles, supervises the run, acks done.
// One request in flight: req_ready is low from accept until the cycle after the response pulse.
module timer_launcher #(
  parameter int GAP      = 2,
  parameter int START_TO = 4
) (
  input logic              clk,
  input logic              reset,
  timer_launcher_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_SEND, S_WAIT_CNT, S_WAIT_DONE, S_ACK, S_RSP
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  localparam logic [7:0] TO_LAST  = 8'(START_TO - 1);

  state_t     state;
  logic [7:0] cnt;       // gap length, then start timeout
  logic [2:0] bit_cnt;
  logic [7:0] sreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      sreg          <= '0;
      bus.req_ready <= 1'b1;
      bus.ser_out   <= 1'b0;
      bus.ack       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_delay <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            sreg          <= {4'b1101, bus.req_delay};
            bus.rsp_delay <= bus.req_delay;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b0;
            cnt           <= '0;
            state         <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            bus.ser_out <= sreg[7];
            sreg        <= {sreg[6:0], 1'b0};
            state       <= S_SEND;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SEND: begin
          if (bit_cnt == 3'd7) begin
            bus.ser_out <= 1'b0;
            cnt         <= '0;
            state       <= S_WAIT_CNT;
          end else begin
            bus.ser_out <= sreg[7];
            sreg        <= {sreg[6:0], 1'b0};
            bit_cnt     <= bit_cnt + 3'd1;
          end
        end
        S_WAIT_CNT: begin
          // A run short enough to finish before counting is noticed still gets acked.
          if (bus.tmr_done) begin
            bus.ack <= 1'b1;
            state   <= S_ACK;
          end else if (bus.tmr_counting) begin
            state <= S_WAIT_DONE;
          end else if (cnt == TO_LAST) begin
            cnt           <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            state         <= S_RSP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.tmr_done) begin
            bus.ack <= 1'b1;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          bus.ack       <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state         <= S_RSP;
        end
        S_RSP: begin
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: begin
          bus.ser_out   <= 1'b0;
          bus.ack       <= 1'b0;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_launcher.sv
// Directed bench for timer_launcher with a behavioural serial-triggered timer model.
module tb_timer_launcher;
  localparam int GAP      = 2;
  localparam int START_TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   model_en   = 1'b1;
  bit   force_done = 1'b0;

  timer_launcher_if bus ();

  timer_launcher #(.GAP(GAP), .START_TO(START_TO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Timer model: detect 1101, read 4 delay bits MSB first, count (code+1)*1000, hold done until ack.
  logic [3:0] hist, m_code, m_last;
  logic [1:0] m_st, bcnt;
  int         mcnt, mtarget;
  logic       m_counting, m_done;

  assign bus.tmr_counting = m_counting;
  assign bus.tmr_done     = m_done | force_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0; m_code <= '0; m_last <= '0; m_st <= '0; bcnt <= '0;
      mcnt <= 0; mtarget <= 0; m_counting <= 1'b0; m_done <= 1'b0;
    end else begin
      case (m_st)
        2'd0: if (model_en) begin
          hist <= {hist[2:0], bus.ser_out};
          if ({hist[2:0], bus.ser_out} == 4'b1101) begin
            m_st <= 2'd1;
            bcnt <= '0;
          end
        end
        2'd1: begin
          m_code <= {m_code[2:0], bus.ser_out};
          bcnt   <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            m_last     <= {m_code[2:0], bus.ser_out};
            mtarget    <= (int'({m_code[2:0], bus.ser_out}) + 1) * 1000;
            mcnt       <= 0;
            m_counting <= 1'b1;
            m_st       <= 2'd2;
          end
        end
        2'd2: begin
          mcnt <= mcnt + 1;
          if (mcnt == mtarget - 1) begin
            m_counting <= 1'b0;
            m_done     <= 1'b1;
            m_st       <= 2'd3;
          end
        end
        default: if (bus.ack) begin
          m_done <= 1'b0;
          hist   <= '0;
          m_st   <= 2'd0;
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_accept(input logic [3:0] d);
    @(negedge clk);
    chk("acc_rdy", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_delay = d;
    @(posedge clk);
  endtask

  // Called right after the accept edge E0; loop index c is cycle E0+c.
  task automatic run_mon(input string tag, input logic [3:0] d, input bit exp_err,
                         input bit toggle, input bit hold, input logic [3:0] next_d);
    logic [10:0] ser = '0;
    int   c_done = -1, c_ack = -1, c_rsp = -1, n_ack = 0;
    logic rsp_err_s = 1'b0;
    logic [3:0] rsp_d_s = '0;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) bus.req_delay = next_d;
        else      bus.req_valid = 1'b0;
      end
      if (toggle) bus.req_delay = bus.req_delay ^ 4'hF;
      if (c <= 11) ser = {ser[9:0], bus.ser_out};
      if (bus.tmr_done && c_done < 0) c_done = c;
      if (bus.ack) begin
        n_ack++;
        if (c_ack < 0) c_ack = c;
      end
      if (bus.rsp_valid) begin
        c_rsp     = c;
        rsp_err_s = bus.rsp_err;
        rsp_d_s   = bus.rsp_delay;
        break;
      end
    end
    chk({tag, "_ser"}, 32'(ser), 32'({2'b00, 4'b1101, d, 1'b0}));
    chk({tag, "_rsp_seen"}, 32'(c_rsp > 0), 32'd1);
    chk({tag, "_rsp_err"}, 32'(rsp_err_s), 32'(exp_err));
    chk({tag, "_rsp_delay"}, 32'(rsp_d_s), 32'(d));
    chk({tag, "_ack_cnt"}, 32'(n_ack), exp_err ? 32'd0 : 32'd1);
    if (exp_err) begin
      chk({tag, "_rsp_cycle"}, 32'(c_rsp), 32'(GAP + 9 + START_TO));
    end else begin
      chk({tag, "_tmr_code"}, 32'(m_last), 32'(d));
      chk({tag, "_ack_cycle"}, 32'(c_ack), 32'(c_done + 1));
      chk({tag, "_rsp_cycle"}, 32'(c_rsp), 32'(c_done + 2));
    end
    @(negedge clk);
    chk({tag, "_rdy_after"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int quiet;
    bus.req_valid = 1'b0;
    bus.req_delay = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_ser", 32'(bus.ser_out), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_delay", 32'(bus.rsp_delay), 32'd0);
    rst_n = 1'b1;

    do_accept(4'h3);
    run_mon("d3", 4'h3, 1'b0, 1'b0, 1'b0, 4'h0);

    do_accept(4'h0);
    run_mon("d0", 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

    model_en = 1'b0;
    do_accept(4'h9);
    run_mon("tmo", 4'h9, 1'b1, 1'b0, 1'b0, 4'h0);
    model_en = 1'b1;

    // Back-to-back with req_valid held: second accept is the edge after the first RSP.
    do_accept(4'hF);
    run_mon("b2b_f", 4'hF, 1'b0, 1'b0, 1'b1, 4'h1);
    @(posedge clk);
    run_mon("b2b_1", 4'h1, 1'b0, 1'b0, 1'b0, 4'h0);

    do_accept(4'hA);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
    end
    chk("mid_bit5", 32'(bus.ser_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ser", 32'(bus.ser_out), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.ack) quiet++;
    end
    chk("mid_rst_quiet", 32'(quiet), 32'd0);
    do_accept(4'h2);
    run_mon("after_rst", 4'h2, 1'b0, 1'b0, 1'b0, 4'h0);

    force_done = 1'b1;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack || bus.rsp_valid) quiet++;
    end
    force_done = 1'b0;
    chk("stale_done_ack", 32'(quiet), 32'd0);
    chk("stale_done_ready", 32'(bus.req_ready), 32'd1);
    do_accept(4'h6);
    run_mon("toggle", 4'h6, 1'b0, 1'b1, 1'b0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
